// File: rtl/mwrite_sbuf.sv
// rtl/mwrite_sbuf.sv - memory-write stage: byte-merging, coalescing store buffer plus write-back registers
module mwrite_sbuf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                STALL,
    output logic                STALL_REQ,
    output logic                DATA_WREN,
    input  logic                DATA_WREADY,
    output logic [ADDR_W-1:0]   DATA_WADDR,
    output logic [DATA_W-1:0]   DATA_WDATA,
    input  logic                MEMR_MEM_R_VALID,
    input  logic [4:0]          MEMR_MEM_R_RD,
    input  logic [DATA_W-1:0]   MEMR_MEM_R_DATA,
    input  logic [4:0]          MEMR_REG_W_RD,
    input  logic [DATA_W-1:0]   MEMR_REG_W_DATA,
    input  logic [11:0]         MEMR_CSR_W_ADDR,
    input  logic [DATA_W-1:0]   MEMR_CSR_W_DATA,
    input  logic                MEMR_MEM_W_VALID,
    input  logic [ADDR_W-1:0]   MEMR_MEM_W_ADDR,
    input  logic [DATA_W/8-1:0] MEMR_MEM_W_STRB,
    input  logic [DATA_W-1:0]   MEMR_MEM_W_DATA,
    input  logic [ADDR_W-1:0]   LD_CHK_ADDR,
    output logic                LD_CHK_HIT,
    output logic                SBUF_EMPTY,
    output logic [4:0]          MEMW_REG_W_RD,
    output logic [DATA_W-1:0]   MEMW_REG_W_DATA,
    output logic [11:0]         MEMW_CSR_W_ADDR,
    output logic [DATA_W-1:0]   MEMW_CSR_W_DATA
);
    localparam int NB = DATA_W / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [ADDR_W-1:0] addr_d  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [4:0]        reg_rd_q, reg_rd_d;
    logic [DATA_W-1:0] reg_data_q, reg_data_d;
    logic [11:0]       csr_addr_q, csr_addr_d;
    logic [DATA_W-1:0] csr_data_q, csr_data_d;

    logic [PW-1:0]     youngest;
    logic [NB-1:0]     eff_strb;
    logic              coalesce, push, pop;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     strb
    );
        logic [DATA_W-1:0] res;
        for (int i = 0; i < NB; i++) begin
            res[i*8 +: 8] = strb[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        reg_rd_d   = reg_rd_q;
        reg_data_d = reg_data_q;
        csr_addr_d = csr_addr_q;
        csr_data_d = csr_data_q;

        // an all-zero strobe is a legacy full-word write
        eff_strb = (MEMR_MEM_W_STRB == '0) ? '1 : MEMR_MEM_W_STRB;
        youngest = tail_q - PW'(1);

        // count>=2 guarantees the youngest entry is not the head the MMU may be reading
        coalesce = MEMR_MEM_W_VALID && !STALL && (count_q >= CW'(2))
                   && (addr_q[youngest] == MEMR_MEM_W_ADDR);
        push     = MEMR_MEM_W_VALID && !STALL && !coalesce && (count_q != CW'(DEPTH));
        pop      = (count_q != '0) && DATA_WREADY;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (coalesce) begin
            data_d[youngest] = merge_bytes(data_q[youngest], MEMR_MEM_W_DATA, eff_strb);
        end
        if (push) begin
            addr_d[tail_q]  = MEMR_MEM_W_ADDR;
            data_d[tail_q]  = merge_bytes(MEMR_MEM_R_DATA, MEMR_MEM_W_DATA, eff_strb);
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (!STALL) begin
            reg_rd_d   = MEMR_MEM_R_VALID ? MEMR_MEM_R_RD   : MEMR_REG_W_RD;
            reg_data_d = MEMR_MEM_R_VALID ? MEMR_MEM_R_DATA : MEMR_REG_W_DATA;
            csr_addr_d = MEMR_CSR_W_ADDR;
            csr_data_d = MEMR_CSR_W_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            reg_rd_q   <= '0;
            reg_data_q <= '0;
            csr_addr_q <= '0;
            csr_data_q <= '0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            reg_rd_q   <= reg_rd_d;
            reg_data_q <= reg_data_d;
            csr_addr_q <= csr_addr_d;
            csr_data_q <= csr_data_d;
        end
    end

    always_comb begin
        LD_CHK_HIT = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == LD_CHK_ADDR)) LD_CHK_HIT = 1'b1;
        end
    end

    // depends only on registered count, so DATA_WREADY never reaches STALL_REQ
    assign STALL_REQ       = MEMR_MEM_W_VALID && (count_q == CW'(DEPTH)) && !coalesce;
    assign DATA_WREN       = (count_q != '0);
    assign DATA_WADDR      = addr_q[head_q];
    assign DATA_WDATA      = data_q[head_q];
    assign SBUF_EMPTY      = (count_q == '0);
    assign MEMW_REG_W_RD   = reg_rd_q;
    assign MEMW_REG_W_DATA = reg_data_q;
    assign MEMW_CSR_W_ADDR = csr_addr_q;
    assign MEMW_CSR_W_DATA = csr_data_q;
endmodule

// File: tb/tb_mwrite_sbuf.sv
// tb/tb_mwrite_sbuf.sv - directed self-checking bench for mwrite_sbuf
module tb_mwrite_sbuf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        stall_req;
    logic        wren;
    logic        wready;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        r_valid;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic [4:0]  reg_rd;
    logic [31:0] reg_data;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic        w_valid;
    logic [31:0] w_addr;
    logic [3:0]  w_strb;
    logic [31:0] w_data;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        empty;
    logic [4:0]  o_rd;
    logic [31:0] o_data;
    logic [11:0] o_csr_addr;
    logic [31:0] o_csr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mwrite_sbuf #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .CLK(clk), .RST_N(rst_n), .STALL(stall), .STALL_REQ(stall_req),
        .DATA_WREN(wren), .DATA_WREADY(wready), .DATA_WADDR(waddr), .DATA_WDATA(wdata),
        .MEMR_MEM_R_VALID(r_valid), .MEMR_MEM_R_RD(r_rd), .MEMR_MEM_R_DATA(r_data),
        .MEMR_REG_W_RD(reg_rd), .MEMR_REG_W_DATA(reg_data),
        .MEMR_CSR_W_ADDR(csr_addr), .MEMR_CSR_W_DATA(csr_data),
        .MEMR_MEM_W_VALID(w_valid), .MEMR_MEM_W_ADDR(w_addr), .MEMR_MEM_W_STRB(w_strb),
        .MEMR_MEM_W_DATA(w_data), .LD_CHK_ADDR(ld_addr), .LD_CHK_HIT(ld_hit),
        .SBUF_EMPTY(empty), .MEMW_REG_W_RD(o_rd), .MEMW_REG_W_DATA(o_data),
        .MEMW_CSR_W_ADDR(o_csr_addr), .MEMW_CSR_W_DATA(o_csr_data)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] w, input logic [31:0] r);
        w_valid = 1'b1; w_addr = a; w_strb = s; w_data = w; r_data = r;
        tick();
        w_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] a, input logic [31:0] d);
        check_val({tag, "_wren"}, 64'(wren), 64'd1);
        check_val({tag, "_addr"}, 64'(waddr), 64'(a));
        check_val({tag, "_data"}, 64'(wdata), 64'(d));
        wready = 1'b1;
        tick();
        wready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; wready = 1'b0;
        r_valid = 1'b0; r_rd = '0; r_data = '0; reg_rd = '0; reg_data = '0;
        csr_addr = '0; csr_data = '0; w_valid = 1'b0; w_addr = '0; w_strb = '0;
        w_data = '0; ld_addr = '0;
        repeat (2) tick();
        check_val("rst_wren", 64'(wren), 64'd0);
        check_val("rst_stall_req", 64'(stall_req), 64'd0);
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_ld_hit", 64'(ld_hit), 64'd0);
        check_val("rst_rd", 64'(o_rd), 64'd0);
        rst_n = 1'b1;
        tick();

        // byte merge
        store(32'h40, 4'b0101, 32'h11223344, 32'hAABBCCDD);
        pop_expect("merge_0101", 32'h40, 32'hAA22CC44);
        store(32'h44, 4'b0000, 32'h11223344, 32'hAABBCCDD);
        pop_expect("merge_zero", 32'h44, 32'h11223344);
        check_val("merge_empty", 64'(empty), 64'd1);

        // full / backpressure
        for (int i = 0; i < 4; i++) store(32'(i * 4), 4'hF, 32'(i + 1), 32'h0);
        check_val("full_no_req_idle", 64'(stall_req), 64'd0);
        w_valid = 1'b1; w_addr = 32'h10; w_strb = 4'hF; w_data = 32'h5; #1;
        check_val("full_stall_req", 64'(stall_req), 64'd1);
        tick();
        check_val("full_hold_req", 64'(stall_req), 64'd1);
        check_val("full_head", 64'(waddr), 64'h0);
        wready = 1'b1; #1;
        check_val("full_no_bypass", 64'(stall_req), 64'd1);
        tick();
        wready = 1'b0; #1;
        check_val("full_after_pop", 64'(stall_req), 64'd0);
        tick();
        w_valid = 1'b0;
        pop_expect("drain0", 32'h04, 32'h2);
        pop_expect("drain1", 32'h08, 32'h3);
        pop_expect("drain2", 32'h0C, 32'h4);
        pop_expect("drain3", 32'h10, 32'h5);
        check_val("drain_empty", 64'(empty), 64'd1);

        // coalesce behind a head entry
        store(32'h50, 4'hF, 32'hCAFE0000, 32'h0);
        store(32'h100, 4'b0001, 32'h000000FF, 32'h12345678);
        store(32'h100, 4'b0010, 32'h0000FF00, 32'h12345678);
        pop_expect("coal_head", 32'h50, 32'hCAFE0000);
        pop_expect("coal_merged", 32'h100, 32'h1234FFFF);
        check_val("coal_one_entry", 64'(empty), 64'd1);
        store(32'h100, 4'b0001, 32'h000000FF, 32'h12345678);
        store(32'h100, 4'b0010, 32'h0000FF00, 32'h12345678);
        pop_expect("nocoal_a", 32'h100, 32'h123456FF);
        pop_expect("nocoal_b", 32'h100, 32'h1234FF78);
        check_val("nocoal_empty", 64'(empty), 64'd1);

        // hazard and order
        store(32'h10, 4'hF, 32'hA, 32'h0);
        store(32'h14, 4'hF, 32'hB, 32'h0);
        store(32'h18, 4'hF, 32'hC, 32'h0);
        ld_addr = 32'h14; #1;
        check_val("hit_mid", 64'(ld_hit), 64'd1);
        ld_addr = 32'h10; #1;
        check_val("hit_head", 64'(ld_hit), 64'd1);
        ld_addr = 32'h20; #1;
        check_val("hit_miss", 64'(ld_hit), 64'd0);
        pop_expect("order0", 32'h10, 32'hA);
        pop_expect("order1", 32'h14, 32'hB);
        pop_expect("order2", 32'h18, 32'hC);
        ld_addr = 32'h14; #1;
        check_val("hit_stale", 64'(ld_hit), 64'd0);

        // forwarding and stall
        r_valid = 1'b1; r_rd = 5'd5; r_data = 32'h1234;
        reg_rd = 5'd7; reg_data = 32'h9999; csr_addr = 12'h300; csr_data = 32'hABCD;
        tick();
        check_val("fwd_rd", 64'(o_rd), 64'd5);
        check_val("fwd_data", 64'(o_data), 64'h1234);
        check_val("fwd_csr_addr", 64'(o_csr_addr), 64'h300);
        check_val("fwd_csr_data", 64'(o_csr_data), 64'hABCD);
        stall = 1'b1; r_valid = 1'b0; csr_addr = 12'h341; csr_data = 32'h55;
        w_valid = 1'b1; w_addr = 32'h80; w_strb = 4'hF; w_data = 32'h77;
        repeat (2) tick();
        check_val("stall_rd", 64'(o_rd), 64'd5);
        check_val("stall_data", 64'(o_data), 64'h1234);
        check_val("stall_csr", 64'(o_csr_addr), 64'h300);
        check_val("stall_no_push", 64'(empty), 64'd1);
        stall = 1'b0; w_valid = 1'b0;
        tick();
        check_val("unstall_rd", 64'(o_rd), 64'd7);
        check_val("unstall_data", 64'(o_data), 64'h9999);
        check_val("unstall_csr", 64'(o_csr_data), 64'h55);

        // asynchronous reset mid-drain
        store(32'h200, 4'hF, 32'h1, 32'h0);
        store(32'h204, 4'hF, 32'h2, 32'h0);
        store(32'h208, 4'hF, 32'h3, 32'h0);
        wready = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_wren", 64'(wren), 64'd0);
        check_val("arst_empty", 64'(empty), 64'd1);
        check_val("arst_rd", 64'(o_rd), 64'd0);
        check_val("arst_data", 64'(o_data), 64'd0);
        check_val("arst_csr", 64'(o_csr_addr), 64'd0);
        check_val("arst_csr_data", 64'(o_csr_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("post_rst_empty", 64'(empty), 64'd1);
        wready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
